// File: rtl/ps_pkg.sv
// ps_pkg: next-address source encoding and sizing helper for program_sequencer_stack.
package ps_pkg;
   typedef enum logic [2:0] {NA_RST, NA_HOLD, NA_JMP, NA_CALL, NA_RET, NA_LOOP, NA_INC} na_src_e;
   function automatic int sp_w(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/ps_return_stack.sv
// ps_return_stack: STACK_DEPTH x PC_W LIFO of return addresses with push/pop/top and sync clear.
module ps_return_stack
   import ps_pkg::*;
#(
   parameter int PC_W = 8,
   parameter int STACK_DEPTH = 4,
   localparam int SPW = sp_w(STACK_DEPTH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr_i,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic [PC_W-1:0] din_i,
   output logic [PC_W-1:0] top_o,
   output logic [SPW-1:0]  sp_o,
   output logic            full_o,
   output logic            empty_o
);
   localparam int AW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
   logic [PC_W-1:0] mem_q [2**AW];
   logic [SPW-1:0]  sp_q;
   assign full_o  = sp_q == SPW'(STACK_DEPTH);
   assign empty_o = sp_q == '0;
   assign top_o   = mem_q[AW'(sp_q - 1'b1)];
   assign sp_o    = sp_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sp_q <= '0;
      else if (clr_i) sp_q <= '0;
      else if (push_i && !full_o) sp_q <= sp_q + 1'b1;
      else if (pop_i && !empty_o) sp_q <= sp_q - 1'b1;
   always_ff @(posedge clk)
      if (push_i && !full_o && !clr_i) mem_q[AW'(sp_q)] <= din_i;
endmodule

// File: rtl/program_sequencer_stack.sv
// program_sequencer_stack: prioritised next-fetch-address mux, pc register, call/return stack,
// sticky stack flags; zero-overhead loop enabled by defining PS_LOOP_EN.
module program_sequencer_stack
   import ps_pkg::*;
#(
   parameter int PC_W = 8,
   parameter int JMP_W = 4,
   parameter int STACK_DEPTH = 4,
   parameter int LOOP_W = 8
) (
   input  logic              clk,
   input  logic              async_reset_n,
   input  logic              sync_reset,
   input  logic              hold,
   input  logic              jmp,
   input  logic              jmp_nz,
   input  logic              dont_jmp,
   input  logic              call,
   input  logic              ret,
   input  logic [JMP_W-1:0]  jmp_addr,
   input  logic              loop_start,
   input  logic [LOOP_W-1:0] loop_count,
   output logic [PC_W-1:0]   pm_addr,
   output logic [PC_W-1:0]   pc,
   output logic              stack_ovf,
   output logic              stack_unf,
   output logic [7:0]        from_PS
);
   localparam int SPW = sp_w(STACK_DEPTH);
   na_src_e         src;
   logic [PC_W-1:0] pc_q, pc_inc, target, top, nxt, loop_tgt;
   logic [SPW-1:0]  sp;
   logic            full, empty, push, pop, ovf_q, unf_q, loop_hit;
   always_comb begin
      pc_inc = pc_q + 1'b1;
      target = PC_W'(jmp_addr) << (PC_W - JMP_W);
      src = sync_reset ? NA_RST : hold ? NA_HOLD : (jmp || (jmp_nz && !dont_jmp)) ? NA_JMP :
            call ? NA_CALL : ret ? NA_RET : loop_hit ? NA_LOOP : NA_INC;
      case (src)
         NA_RST:          nxt = '0;
         NA_HOLD:         nxt = pc_q;
         NA_JMP, NA_CALL: nxt = target;
         NA_RET:          nxt = empty ? pc_inc : top;
         NA_LOOP:         nxt = loop_tgt;
         default:         nxt = pc_inc;
      endcase
      pm_addr = async_reset_n ? nxt : '0;
   end
   assign push = src == NA_CALL;
   assign pop  = src == NA_RET;
   ps_return_stack #(.PC_W(PC_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
      .clk(clk), .rst_n(async_reset_n), .clr_i(sync_reset), .push_i(push), .pop_i(pop),
      .din_i(pc_inc), .top_o(top), .sp_o(sp), .full_o(full), .empty_o(empty)
   );
   always_ff @(posedge clk or negedge async_reset_n)
      if (!async_reset_n) begin
         pc_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pm_addr;
         ovf_q <= !sync_reset && (ovf_q || (push && full));
         unf_q <= !sync_reset && (unf_q || (pop && empty));
      end
`ifdef PS_LOOP_EN
   logic [PC_W-1:0]   loop_end_q, loop_begin_q;
   logic [LOOP_W-1:0] loop_cnt_q;
   assign loop_hit = pc_q == loop_end_q && loop_cnt_q != '0;
   assign loop_tgt = loop_begin_q;
   // a fresh load takes precedence over the decrement of a loop-back in the same cycle
   always_ff @(posedge clk or negedge async_reset_n)
      if (!async_reset_n) begin
         loop_end_q   <= '0;
         loop_begin_q <= '0;
         loop_cnt_q   <= '0;
      end else if (sync_reset) begin
         loop_end_q   <= '0;
         loop_begin_q <= '0;
         loop_cnt_q   <= '0;
      end else if (!hold && loop_start) begin
         loop_end_q   <= target;
         loop_begin_q <= pc_inc;
         loop_cnt_q   <= loop_count;
      end else if (src == NA_LOOP) begin
         loop_cnt_q   <= loop_cnt_q - 1'b1;
      end
`else
   logic unused_loop;
   assign unused_loop = ^{loop_start, loop_count};
   assign loop_hit = 1'b0;
   assign loop_tgt = '0;
`endif
   assign pc        = pc_q;
   assign stack_ovf = ovf_q;
   assign stack_unf = unf_q;
   assign from_PS   = {ovf_q, unf_q, 6'(sp)};
endmodule

// File: tb/tb_program_sequencer_stack.sv
// tb_program_sequencer_stack: directed and random stimulus checked against a queue-based model.
module tb_program_sequencer_stack;
   logic       clk = 1'b0, rst_n, sr, hold, jmp, jnz, dj, call, ret, ls;
   logic [3:0] ja;
   logic [7:0] lc, pm_addr, pc, from_PS;
   logic       stack_ovf, stack_unf;
   int         checks = 0, errors = 0;
   logic [7:0] m_pc, m_le, m_lb, m_lc, q_pc;
   logic [7:0] stk[$];
   logic       m_ovf, m_unf, m_loop;

   always #5 clk = ~clk;

   program_sequencer_stack dut (
      .clk(clk), .async_reset_n(rst_n), .sync_reset(sr), .hold(hold), .jmp(jmp), .jmp_nz(jnz),
      .dont_jmp(dj), .call(call), .ret(ret), .jmp_addr(ja), .loop_start(ls), .loop_count(lc),
      .pm_addr(pm_addr), .pc(pc), .stack_ovf(stack_ovf), .stack_unf(stack_unf), .from_PS(from_PS)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clr_in();
      {sr, hold, jmp, jnz, dj, call, ret, ls} = '0;
      ja = '0;
      lc = '0;
   endtask

   task automatic model_reset();
      m_pc = 0; m_le = 0; m_lb = 0; m_lc = 0; m_ovf = 0; m_unf = 0;
      stk.delete();
   endtask

   function automatic logic [7:0] model_next();
      m_loop = 0;
      if (sr) return 8'h00;
      if (hold) return m_pc;
      if (jmp || (jnz && !dj) || call) return {ja, 4'h0};
      if (ret) return stk.size() > 0 ? stk[$] : m_pc + 8'd1;
`ifdef PS_LOOP_EN
      if (m_pc == m_le && m_lc != 0) begin
         m_loop = 1;
         return m_lb;
      end
`endif
      return m_pc + 8'd1;
   endfunction

   task automatic model_update(input logic [7:0] nxt);
      if (sr) begin
         stk.delete();
         m_ovf = 0; m_unf = 0; m_le = 0; m_lb = 0; m_lc = 0;
      end else if (!hold) begin
         if (!(jmp || (jnz && !dj))) begin
            if (call) begin
               if (stk.size() < 4) stk.push_back(m_pc + 8'd1);
               else m_ovf = 1;
            end else if (ret) begin
               if (stk.size() > 0) void'(stk.pop_back());
               else m_unf = 1;
            end
         end
`ifdef PS_LOOP_EN
         if (ls) begin
            m_le = {ja, 4'h0}; m_lb = m_pc + 8'd1; m_lc = lc;
         end else if (m_loop) m_lc = m_lc - 8'd1;
`endif
      end
      m_pc = nxt;
   endtask

   task automatic step();
      logic [7:0] e;
      e = model_next();
      #1 chk("pm_addr", pm_addr, e);
      @(posedge clk);
      model_update(e);
      @(negedge clk);
      chk("pc", pc, m_pc);
      chk("from_PS", from_PS, {m_ovf, m_unf, 6'(stk.size())});
   endtask

   task automatic go_jmp(input logic [3:0] a);
      clr_in(); jmp = 1; ja = a; step(); clr_in();
   endtask

   initial begin
      rst_n = 0;
      clr_in();
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_pc", pc, 8'h00);
      chk("rst_pm", pm_addr, 8'h00);
      chk("rst_dbg", from_PS, 8'h00);
      rst_n = 1;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk("count_pc", pc, 8'(i));
      end
      go_jmp(4'hF);
      repeat (15) step();
      chk("pc_ff", pc, 8'hFF);
      step();
      chk("wrap_pc", pc, 8'h00);
      go_jmp(4'hA);
      chk("jmp_pc", pc, 8'hA0);
      jnz = 1; dj = 1; ja = 4'h5; step();
      chk("jnz_not_taken", pc, 8'hA1);
      dj = 0; ja = 4'hA; step(); clr_in();
      chk("jnz_taken", pc, 8'hA0);
      sr = 1; step(); clr_in();
      go_jmp(4'h1);
      call = 1; ja = 4'h3; step(); clr_in();
      chk("call_pc", pc, 8'h30);
      chk("call_sp", from_PS, 8'h01);
      ret = 1; step(); clr_in();
      chk("ret_pc", pc, 8'h11);
      chk("ret_sp", from_PS, 8'h00);
      sr = 1; step(); clr_in();
      for (int i = 1; i <= 5; i++) begin
         call = 1; ja = 4'(i); step();
      end
      clr_in();
      chk("ovf_pc", pc, 8'h50);
      chk("ovf_dbg", from_PS, 8'h84);
      chk("ovf_flag", {7'd0, stack_ovf}, 8'h01);
      ret = 1;
      repeat (5) step();
      clr_in();
      chk("unf_pc", pc, 8'h02);
      chk("unf_dbg", from_PS, 8'hC0);
      sr = 1; step(); clr_in();
      chk("sr_dbg", from_PS, 8'h00);
      chk("sr_pc", pc, 8'h00);
      go_jmp(4'h6);
      q_pc = pc;
      hold = 1; call = 1; ja = 4'h7;
      repeat (3) begin
         step();
         chk("hold_pc", pc, q_pc);
      end
      clr_in();
      chk("hold_sp", from_PS, 8'h00);
      go_jmp(4'h1);
      repeat (15) step();
      ls = 1; ja = 4'h2; lc = 8'd2; step(); clr_in();
      chk("loop_entry", pc, 8'h20);
`ifdef PS_LOOP_EN
      step(); chk("loop_it2", pc, 8'h20);
      step(); chk("loop_it3", pc, 8'h20);
      step(); chk("loop_exit", pc, 8'h21);
`else
      step(); chk("noloop_1", pc, 8'h21);
      step(); chk("noloop_2", pc, 8'h22);
`endif
      #2 rst_n = 0;
      #1;
      chk("arst_pc", pc, 8'h00);
      chk("arst_pm", pm_addr, 8'h00);
      chk("arst_dbg", from_PS, 8'h00);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      step();
      chk("arst_release", pc, 8'h01);
      for (int i = 0; i < 3000; i++) begin
         sr   = $urandom_range(0, 40) == 0;
         hold = $urandom_range(0, 7) == 0;
         jmp  = $urandom_range(0, 7) == 0;
         jnz  = $urandom_range(0, 5) == 0;
         dj   = $urandom_range(0, 1) == 1;
         call = $urandom_range(0, 4) == 0;
         ret  = $urandom_range(0, 4) == 0;
         ls   = $urandom_range(0, 15) == 0;
         ja   = 4'($urandom);
         lc   = 8'($urandom_range(0, 3));
         step();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
